// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared definitions for the NES button datapath
//
// Purpose: control-word field positions, counter control encodings,
//          controller button codes and committed-button bit indices.
// Ports:   none (package).
package nes_pkg;

  // Control word field positions
  localparam int CW_DLY_HI  = 9;
  localparam int CW_DLY_LO  = 8;
  localparam int CW_CODE_HI = 7;
  localparam int CW_CODE_LO = 4;
  localparam int CW_LATCH   = 3;
  localparam int CW_PULSE   = 2;
  localparam int CW_TICK_HI = 1;
  localparam int CW_TICK_LO = 0;

  // Counter control; 2'b10 is unused and behaves as hold
  typedef enum logic [1:0] {
    CTRL_HOLD = 2'b00,
    CTRL_INC  = 2'b01,
    CTRL_CLR  = 2'b11
  } ctrl_e;

  // Button codes carried in cw[7:4]
  typedef enum logic [3:0] {
    CODE_NONE   = 4'd0,
    CODE_A      = 4'd1,
    CODE_B      = 4'd2,
    CODE_SELECT = 4'd3,
    CODE_START  = 4'd4,
    CODE_UP     = 4'd5,
    CODE_DOWN   = 4'd6,
    CODE_LEFT   = 4'd7,
    CODE_RIGHT  = 4'd8
  } code_e;

  // Bit indices within buttons
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // True for the codes that name a real button slot
  function automatic logic is_sample_code(input logic [3:0] code);
    return (code >= CODE_A) && (code <= CODE_RIGHT);
  endfunction

endpackage

// File: rtl/nes_mod_counter.sv
// rtl/nes_mod_counter.sv - modulo counter with hold/increment/clear control
//
// Purpose: counts 0..MODULUS-1 under ctrl, wrapping on increment at the top.
// Ports:   clk       - clock, rising edge
//          reset_n   - synchronous active-low reset, clears count
//          ctrl      - HOLD / INC / CLR (2'b10 holds)
//          count     - current count
//          terminal  - combinational, high when incrementing from MODULUS-1
module nes_mod_counter
  import nes_pkg::*;
#(
  parameter int MODULUS = 4
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [1:0]                               ctrl,
  output logic [((MODULUS > 1) ? $clog2(MODULUS) : 1)-1:0] count,
  output logic                                     terminal
);

  localparam int W = (MODULUS > 1) ? $clog2(MODULUS) : 1;
  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case (ctrl)
        CTRL_INC: count <= (count == LAST) ? '0 : count + 1'b1;
        CTRL_CLR: count <= '0;
        default:  count <= count;
      endcase
    end
  end

  // Gated by reset_n so the status lines read idle while in reset
  assign terminal = reset_n && (ctrl == CTRL_INC) && (count == LAST);

endmodule

// File: rtl/nes_button_datapath.sv
// rtl/nes_button_datapath.sv - NES controller datapath (timing, sampling, commit)
//
// Purpose: timing counters, latch/pulse drive, serial data capture into a
//          shadow register and atomic commit of a full frame to buttons.
// Ports:   clk           - clock, rising edge
//          reset_n       - synchronous active-low reset
//          cw[9:0]       - control word from the controller FSM
//          nes_data      - asynchronous serial data, low = pressed
//          sw[1:0]       - [1] poll interval elapsed, [0] half-period tick
//          nes_latch     - registered cw[3]
//          nes_pulse     - registered cw[2]
//          buttons[7:0]  - committed button states, 1 = pressed
//          buttons_valid - one-cycle strobe when buttons updates
module nes_button_datapath
  import nes_pkg::*;
#(
  parameter int POLL_CYCLES = 420000,
  parameter int TICK_CYCLES = 150
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] cw,
  input  logic       nes_data,
  output logic [1:0] sw,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons,
  output logic       buttons_valid
);

  localparam int DLY_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [DLY_W-1:0]  delay_count;
  logic [TICK_W-1:0] tick_count;
  logic              dly_term;
  logic              tick_term;

  logic [1:0] dly_ctrl;
  logic [1:0] tick_ctrl;
  logic [3:0] code;

  assign dly_ctrl  = cw[CW_DLY_HI:CW_DLY_LO];
  assign tick_ctrl = cw[CW_TICK_HI:CW_TICK_LO];
  assign code      = cw[CW_CODE_HI:CW_CODE_LO];

  nes_mod_counter #(.MODULUS(POLL_CYCLES)) u_delay (
    .clk      (clk),
    .reset_n  (reset_n),
    .ctrl     (dly_ctrl),
    .count    (delay_count),
    .terminal (dly_term)
  );

  nes_mod_counter #(.MODULUS(TICK_CYCLES)) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .ctrl     (tick_ctrl),
    .count    (tick_count),
    .terminal (tick_term)
  );

  // Counts are only observed through the terminal flags
  logic unused_counts;
  assign unused_counts = ^{delay_count, tick_count};

  assign sw = {dly_term, tick_term};

  // Pin drive: one cycle behind the control word
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nes_latch <= 1'b0;
      nes_pulse <= 1'b0;
    end else begin
      nes_latch <= cw[CW_LATCH];
      nes_pulse <= cw[CW_PULSE];
    end
  end

  // Two-flop synchronizer for the asynchronous controller data
  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= nes_data;
      sync_2 <= sync_1;
    end
  end

  // A tick on a real button slot captures one bit; a tick-counter clear
  // in the same cycle takes priority and discards the sample.
  logic       sample;
  logic [2:0] bit_idx;
  logic [7:0] shadow;
  logic       commit_pending;

  assign sample  = tick_term && is_sample_code(code) && (tick_ctrl != CTRL_CLR);
  assign bit_idx = 3'(code - 4'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (tick_ctrl == CTRL_CLR) begin
      shadow <= '0;
    end else if (sample) begin
      shadow[bit_idx] <= ~sync_2;
    end
  end

  // Commit one cycle after the Right sample so the shadow already holds it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      commit_pending <= 1'b0;
      buttons        <= '0;
      buttons_valid  <= 1'b0;
    end else begin
      commit_pending <= sample && (code == CODE_RIGHT);
      buttons_valid  <= commit_pending;
      if (commit_pending) begin
        buttons <= shadow;
      end
    end
  end

endmodule

// File: tb/tb_nes_button_datapath.sv
// tb/tb_nes_button_datapath.sv - directed self-checking bench for nes_button_datapath
module tb_nes_button_datapath;

  logic       clk;
  logic       reset_n;
  logic [9:0] cw;
  logic       nes_data;
  logic [1:0] sw;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] buttons;
  logic       buttons_valid;

  int n_compared;
  int n_mismatched;
  int valid_cnt;

  nes_button_datapath #(.POLL_CYCLES(20), .TICK_CYCLES(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cw            (cw),
    .nes_data      (nes_data),
    .sw            (sw),
    .nes_latch     (nes_latch),
    .nes_pulse     (nes_pulse),
    .buttons       (buttons),
    .buttons_valid (buttons_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (buttons_valid === 1'b1) valid_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one half-period; returns once the tick edge has passed
  task automatic run_slot(input logic [3:0] code, input logic latch, input logic pulse,
                          input logic data);
    logic seen;
    seen = 1'b0;
    cw = {2'b00, code, latch, pulse, 2'b01};
    nes_data = data;
    for (int i = 0; i < 8 && !seen; i++) begin
      #1;
      if (sw[0] === 1'b1) seen = 1'b1;
      tick();
    end
    if (!seen) check("slot_timeout", 32'(seen), 32'd1);
  endtask

  task automatic frame_prefix(input logic [7:0] pressed, input int last_code);
    run_slot(4'd0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= last_code; k++) begin
      run_slot(4'(k), 1'b0, 1'b0, ~pressed[k-1]);
      run_slot(4'd0, 1'b0, 1'b1, ~pressed[k-1]);
    end
  endtask

  task automatic full_frame(input logic [7:0] pressed);
    int v0;
    v0 = valid_cnt;
    frame_prefix(pressed, 7);
    // Out-of-range code with data low must not touch any bit
    run_slot(4'd10, 1'b0, 1'b0, 1'b0);
    run_slot(4'd0, 1'b0, 1'b1, 1'b1);
    run_slot(4'd8, 1'b0, 1'b0, ~pressed[7]);
    cw = 10'd0;
    #1;
    check("valid_early", 32'(buttons_valid), 32'd0);
    tick();
    check("valid_pulse", 32'(buttons_valid), 32'd1);
    check("buttons_commit", 32'(buttons), 32'(pressed));
    tick();
    check("valid_end", 32'(buttons_valid), 32'd0);
    check("valid_count", 32'(valid_cnt - v0), 32'd1);
  endtask

  initial begin
    int v0;
    n_compared = 0;
    n_mismatched = 0;
    valid_cnt = 0;
    reset_n = 1'b0;
    cw = 10'($urandom);
    nes_data = 1'($urandom);

    // Reset state with random control word
    tick();
    tick();
    cw = 10'($urandom);
    #1;
    check("rst_sw", 32'(sw), 32'd0);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_latch", 32'(nes_latch), 32'd0);
    check("rst_pulse", 32'(nes_pulse), 32'd0);
    check("rst_valid", 32'(buttons_valid), 32'd0);
    cw = 10'b01_0000_0_0_01;
    #1;
    check("rst_sw_inc", 32'(sw), 32'd0);
    tick();
    cw = 10'd0;
    reset_n = 1'b1;
    tick();

    // Poll wrap
    cw = 10'b01_0000_0_0_00;
    for (int i = 1; i <= 20; i++) begin
      #1;
      check("poll_sw1", 32'(sw[1]), 32'(i == 20));
      tick();
    end
    check("poll_count_wrap", 32'(dut.delay_count), 32'd0);
    check("poll_sw1_after", 32'(sw[1]), 32'd0);
    cw = 10'd0;
    tick();

    // Latch/pulse latency
    cw = 10'b00_0000_1_0_00;
    #1;
    check("latch_before", 32'(nes_latch), 32'd0);
    tick();
    check("latch_after", 32'(nes_latch), 32'd1);
    cw = 10'b00_0000_0_1_00;
    tick();
    check("latch_fall", 32'(nes_latch), 32'd0);
    check("pulse_after", 32'(nes_pulse), 32'd1);
    cw = 10'd0;
    tick();
    check("pulse_fall", 32'(nes_pulse), 32'd0);

    // Tick clear mid-count
    cw = 10'b00_0000_0_0_01;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("tclr_pre", 32'(sw[0]), 32'd0);
      tick();
    end
    cw = 10'b00_0000_0_0_11;
    #1;
    check("tclr_clr", 32'(sw[0]), 32'd0);
    tick();
    cw = 10'b00_0000_0_0_01;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("tclr_post", 32'(sw[0]), 32'(i == 4));
      tick();
    end
    cw = 10'd0;
    tick();

    // Full frame: A and Left pressed
    full_frame(8'b0100_0001);

    // Abort after Select, from a committed 8'h00
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    v0 = valid_cnt;
    frame_prefix(8'hFF, 3);
    cw = 10'b00_0000_0_0_11;
    tick();
    cw = 10'd0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_buttons", 32'(buttons), 32'h00);
    check("abort_valid", 32'(valid_cnt - v0), 32'd0);
    full_frame(8'hFF);

    // Mid-frame reset during the Up slot
    full_frame(8'h81);
    v0 = valid_cnt;
    frame_prefix(8'h00, 4);
    cw = 10'b00_0101_0_0_01;
    nes_data = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("mrst_buttons", 32'(buttons), 32'd0);
    check("mrst_valid", 32'(buttons_valid), 32'd0);
    check("mrst_sw", 32'(sw), 32'd0);
    reset_n = 1'b1;
    cw = 10'd0;
    for (int i = 0; i < 4; i++) tick();
    check("mrst_valid_count", 32'(valid_cnt - v0), 32'd0);
    check("mrst_buttons_hold", 32'(buttons), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/nes_button_datapath.md
NES_BUTTON_DATAPATH -- requirements
Module: nes_button_datapath

Interface
REQ-001 Parameter POLL_CYCLES, default 420000, clk cycles per controller poll interval (about 60 Hz at 25.175 MHz).
REQ-002 Parameter TICK_CYCLES, default 150, clk cycles per NES latch/pulse half-period (about 6 us).
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 cw  input  10  control word from the NES controller FSM: [9:8] delay-counter ctrl, [7:4] button code, [3] latch enable, [2] pulse enable, [1:0] tick-counter ctrl.
REQ-006 nes_data  input  1  serial data from the controller; asynchronous; low = pressed.
REQ-007 sw  output  2  status to the FSM: [1] poll interval elapsed, [0] half-period tick.
REQ-008 nes_latch  output  1  latch pin to the controller.
REQ-009 nes_pulse  output  1  clock pin to the controller.
REQ-010 buttons  output  8  committed button states, 1 = pressed: [0] A, [1] B, [2] Select, [3] Start, [4] Up, [5] Down, [6] Left, [7] Right.
REQ-011 buttons_valid  output  1  one-cycle strobe when buttons is updated.

Function
REQ-012 Delay counter SHALL be ceil(log2(POLL_CYCLES)) bits wide, with cw[9:8] controls: 00 hold, 01 increment, 11 clear to 0, 10 hold.
REQ-013 sw[1] SHALL be combinational and SHALL be 1 only when cw[9:8]==01 and the delay count equals POLL_CYCLES-1; on that edge the count SHALL wrap to 0.
REQ-014 Tick counter SHALL be ceil(log2(TICK_CYCLES)) bits wide, with cw[1:0] controls: 00 hold, 01 increment, 11 synchronous clear to 0, 10 hold.
REQ-015 sw[0] SHALL be combinational and SHALL be 1 only when cw[1:0]==01 and the tick count equals TICK_CYCLES-1; on that edge the count SHALL wrap to 0.
REQ-016 nes_latch and nes_pulse SHALL be cw[3] and cw[2] registered, with one cycle of latency.
REQ-017 nes_data SHALL pass through a 2-flop synchronizer; only the synchronized value is sampled.
REQ-018 Sampling SHALL occur only on a cycle where cw[7:4] is in 1..8 and sw[0]==1: shadow bit (code-1) <= ~synchronized nes_data.
REQ-019 Codes 0 and 9..15 SHALL sample nothing.
REQ-020 The cycle after sampling code 8 (Right), the module SHALL set buttons <= shadow, including the just-sampled Right bit, and pulse buttons_valid high for exactly one cycle.
REQ-021 cw[1:0]==11 SHALL clear the shadow register.
REQ-022 Aborting a frame before Right is sampled SHALL leave buttons unchanged and SHALL NOT pulse buttons_valid.
REQ-023 If a sample and a tick-counter clear occur on the same cycle, the clear SHALL win.
REQ-024 buttons SHALL hold its value between commits.

Reset
REQ-025 reset_n low SHALL clear, on the next edge, both counters, the synchronizer, shadow, buttons, buttons_valid, nes_latch and nes_pulse to 0.
REQ-026 sw SHALL read 00 while in reset.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame and produce no buttons_valid.

Structure
REQ-028 Shared package nes_pkg SHALL hold: cw field bit positions, counter ctrl encodings (HOLD=00, INC=01, CLR=11), button codes (NONE=0, A=1 .. RIGHT=8), and buttons bit indices.
REQ-029 One sub-module, nes_mod_counter, SHALL be instantiated twice (delay counter and tick counter).
REQ-030 nes_mod_counter SHALL provide: parameter MODULUS; inputs ctrl[1:0] and reset_n; outputs count and terminal = (ctrl==INC && count==MODULUS-1).

Verification (POLL_CYCLES=20, TICK_CYCLES=4)
REQ-031 Reset: assert reset_n low with random cw -> sw=00, buttons=0, nes_latch=0, nes_pulse=0, buttons_valid=0.
REQ-032 Poll wrap: cw[9:8]=01 for 20 cycles -> sw[1] high only on the 20th cycle; the delay count is 0 on the 21st.
REQ-033 Tick clear mid-count: increment 2 cycles, apply cw[1:0]=11 for 1 cycle, then increment -> sw[0] asserts only after 4 further increment cycles.
REQ-034 Full frame: drive FSM-accurate cw with nes_data low in the A and Left slots -> buttons=8'b0100_0001 and buttons_valid is exactly one pulse, one cycle after Right is sampled.
REQ-035 Abort: cw[1:0]=11 after the Select sample of a frame with all buttons pressed, previous buttons=8'h00 -> buttons stays 8'h00 and there is no valid pulse; the next full frame commits 8'hFF.
REQ-036 Mid-frame reset: reset_n low during the Up slot, after a prior commit of 8'h81 -> buttons=0 on the next edge and no valid pulse.
